rr_priority_encoder: RTL and testbench

//  Registered, parametrised successor of the combinational priority encoder.

---
 rtl/rr_priority_encoder_if.sv | 35 +++
 rtl/rr_priority_encoder.sv | 107 ++++++++++
 tb/tb_rr_priority_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rr_priority_encoder_if.sv
// Request/grant bundle for rr_priority_encoder.
//  req         request lines from the sources
//  out_ready   consumer accepts the presented grant this cycle
//  out_valid   out_enc/out_onehot hold a valid grant
//  out_enc     encoded index of the granted request
//  out_onehot  one-hot form of out_enc
// slave  = encoder side, master = source/consumer side.
interface rr_priority_encoder_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(WIDTH)
);

  logic [WIDTH-1:0]      req;
  logic                  out_ready;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_enc;
  logic [WIDTH-1:0]      out_onehot;

  modport master (
    output req,
    output out_ready,
    input  out_valid,
    input  out_enc,
    input  out_onehot
  );

  modport slave (
    input  req,
    input  out_ready,
    output out_valid,
    output out_enc,
    output out_onehot
  );

endinterface

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder with optional round-robin arbitration.
// Picks one of WIDTH request lines per grant and holds it on a valid/ready
// output until accepted. RR_EN=0: highest set index wins. RR_EN=1: search
// starts at ptr and walks downward with wrap; ptr moves below each winner.
// Ports:
//  clk  rising-edge clock
//  rst  synchronous active-high reset
//  bus  slave side of rr_priority_encoder_if (req, out_ready in;
//       out_valid, out_enc, out_onehot out, all registered)
module rr_priority_encoder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(WIDTH),
  parameter int unsigned RR_EN      = 1
) (
  input logic                clk,
  input logic                rst,
  rr_priority_encoder_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WIDTH - 1);

  // Registered state
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_enc_q;
  logic [WIDTH-1:0]      out_onehot_q;
  logic [ADDR_WIDTH-1:0] ptr_q;

  // Next-state values
  logic                  out_valid_nxt;
  logic [ADDR_WIDTH-1:0] out_enc_nxt;
  logic [WIDTH-1:0]      out_onehot_nxt;
  logic [ADDR_WIDTH-1:0] ptr_nxt;

  // Search helpers
  logic                  slot_free;
  logic [ADDR_WIDTH-1:0] search_ptr;
  logic [ADDR_WIDTH-1:0] cand;
  logic                  win_found;
  logic [ADDR_WIDTH-1:0] win_idx;

  // A new grant may be loaded when nothing is held or the held one leaves now.
  assign slot_free = !out_valid_q || bus.out_ready;

  // Fixed mode always starts from the top index, which gives highest-wins.
  assign search_ptr = (RR_EN != 0) ? ptr_q : LAST_IDX;

  // Walk ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1; first set line wins.
  // Wrap is modulo WIDTH so non-power-of-two widths never yield index >= WIDTH.
  always_comb begin : win_search
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i <= int'(search_ptr)) begin
        cand = search_ptr - ADDR_WIDTH'(i);
      end else begin
        cand = ADDR_WIDTH'(int'(search_ptr) + int'(WIDTH) - i);
      end
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state: hold on stall, load winner or clear when the slot is free.
  always_comb begin : next_state
    out_valid_nxt  = out_valid_q;
    out_enc_nxt    = out_enc_q;
    out_onehot_nxt = out_onehot_q;
    ptr_nxt        = ptr_q;
    if (slot_free) begin
      if (win_found) begin
        out_valid_nxt  = 1'b1;
        out_enc_nxt    = win_idx;
        out_onehot_nxt = WIDTH'(1) << win_idx;
        if (RR_EN != 0) begin
          ptr_nxt = (win_idx == '0) ? LAST_IDX : (win_idx - ADDR_WIDTH'(1));
        end
      end else begin
        out_valid_nxt  = 1'b0;
        out_enc_nxt    = '0;
        out_onehot_nxt = '0;
      end
    end
  end

  // State register; reset drops any pending grant.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_enc_q    <= '0;
      out_onehot_q <= '0;
      ptr_q        <= LAST_IDX;
    end else begin
      out_valid_q  <= out_valid_nxt;
      out_enc_q    <= out_enc_nxt;
      out_onehot_q <= out_onehot_nxt;
      ptr_q        <= ptr_nxt;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_enc    = out_enc_q;
  assign bus.out_onehot = out_onehot_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder: fixed and round-robin WIDTH=8
// instances driven in lockstep from a vector table, plus a WIDTH=5 round-robin
// instance exercising the non-power-of-two wrap.
module tb_rr_priority_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_priority_encoder_if #(.WIDTH(8)) fix_if ();
  rr_priority_encoder_if #(.WIDTH(8)) rr_if ();
  rr_priority_encoder_if #(.WIDTH(5)) w5_if ();

  rr_priority_encoder #(.WIDTH(8), .RR_EN(0)) u_fix (
    .clk (clk),
    .rst (rst),
    .bus (fix_if)
  );

  rr_priority_encoder #(.WIDTH(8), .RR_EN(1)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_if)
  );

  rr_priority_encoder #(.WIDTH(5), .RR_EN(1)) u_w5 (
    .clk (clk),
    .rst (rst),
    .bus (w5_if)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       exp_v;
    logic [2:0] exp_fix;
    logic [2:0] exp_rr;
  } vec_t;

  typedef struct {
    logic       v;
    logic [2:0] fix;
    logic [2:0] rr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input int act, input int req_val);
    n_total++;
    if (act == req_val) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req_val);
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic rd,
                     input logic v, input logic [2:0] f, input logic [2:0] rr);
    vec_t e;
    e.rst = r; e.req = q; e.rdy = rd; e.exp_v = v; e.exp_fix = f; e.exp_rr = rr;
    vecs.push_back(e);
  endtask

  task automatic apply(input logic r, input logic [7:0] q, input logic rd);
    rst              = r;
    fix_if.req       = q;
    fix_if.out_ready = rd;
    rr_if.req        = q;
    rr_if.out_ready  = rd;
    w5_if.req        = q[4:0];
    w5_if.out_ready  = rd;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    logic [7:0] oh;

    // rst, req, rdy | valid, fixed enc, rr enc
    add(1, 8'hFF, 0, 0, 0, 0);         // reset state
    add(0, 8'b1001_0010, 1, 1, 7, 7);  // rr ptr 7 -> 6
    add(0, 8'b1001_0010, 1, 1, 7, 4);  // rr ptr 6 -> 3
    add(0, 8'b1001_0010, 1, 1, 7, 1);  // rr ptr 3 -> 0
    add(1, 8'hFF, 1, 0, 0, 0);         // reset wins over ready
    add(0, 8'hFF, 1, 1, 7, 7);
    add(0, 8'hFF, 1, 1, 7, 6);
    add(0, 8'hFF, 1, 1, 7, 5);
    add(0, 8'hFF, 1, 1, 7, 4);
    add(0, 8'hFF, 1, 1, 7, 3);
    add(0, 8'hFF, 1, 1, 7, 2);
    add(0, 8'hFF, 1, 1, 7, 1);
    add(0, 8'hFF, 1, 1, 7, 0);         // win 0 wraps ptr to 7
    add(0, 8'hFF, 1, 1, 7, 7);         // rr ptr -> 6
    add(0, 8'h05, 1, 1, 2, 2);         // rr ptr 6 -> 1
    add(0, 8'h05, 1, 1, 2, 0);         // rr ptr 1 -> 7
    add(0, 8'h05, 1, 1, 2, 2);
    add(0, 8'h05, 1, 1, 2, 0);
    add(0, 8'h00, 1, 0, 0, 0);         // accepted with no requests
    add(0, 8'h20, 1, 1, 5, 5);         // grant 5, rr ptr -> 4
    add(0, 8'h01, 0, 1, 5, 5);         // stall, req change ignored
    add(0, 8'h01, 0, 1, 5, 5);
    add(0, 8'h01, 0, 1, 5, 5);
    add(0, 8'h01, 1, 1, 0, 0);         // accepted, next winner 0, ptr -> 7
    add(0, 8'hFF, 0, 1, 0, 0);         // stall holds 0
    add(0, 8'hFF, 1, 1, 7, 7);         // ptr still 7, -> 6
    add(0, 8'hFF, 0, 1, 7, 7);         // stall
    add(1, 8'hFF, 0, 0, 0, 0);         // reset drops pending grant
    add(0, 8'hFF, 1, 1, 7, 7);         // ptr back at 7 (would be 6 otherwise)

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].rdy);
      e.v = vecs[i].exp_v; e.fix = vecs[i].exp_fix; e.rr = vecs[i].exp_rr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check($sformatf("v%0d fix valid", i), int'(fix_if.out_valid), int'(got.v));
      check($sformatf("v%0d fix enc", i), int'(fix_if.out_enc), int'(got.fix));
      oh = got.v ? (8'(1) << got.fix) : 8'h00;
      check($sformatf("v%0d fix onehot", i), int'(fix_if.out_onehot), int'(oh));
      check($sformatf("v%0d rr valid", i), int'(rr_if.out_valid), int'(got.v));
      check($sformatf("v%0d rr enc", i), int'(rr_if.out_enc), int'(got.rr));
      oh = got.v ? (8'(1) << got.rr) : 8'h00;
      check($sformatf("v%0d rr onehot", i), int'(rr_if.out_onehot), int'(oh));
    end

    // WIDTH=5 round-robin: wrap from 0 goes to 4, never to 5..7
    apply(1, 8'hFF, 1);
    @(posedge clk);
    #1;
    check("w5 reset valid", int'(w5_if.out_valid), 0);
    for (int k = 0; k < 7; k++) begin
      logic [4:0] oh5;
      int ex;
      ex = (k < 5) ? (4 - k) : (9 - k);  // 4,3,2,1,0,4,3
      apply(0, 8'hFF, 1);
      @(posedge clk);
      #1;
      oh5 = 5'(1) << ex;
      check($sformatf("w5 enc step %0d", k), int'(w5_if.out_enc), ex);
      check($sformatf("w5 onehot step %0d", k), int'(w5_if.out_onehot), int'(oh5));
    end

    // WIDTH=5 single request line: always granted regardless of ptr
    for (int k = 0; k < 3; k++) begin
      apply(0, 8'h08, 1);
      @(posedge clk);
      #1;
      check($sformatf("w5 single step %0d", k), int'(w5_if.out_enc), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
